// File: rtl/fir_mac_if.sv
// Tap-stream and output bundle between the delay pipeline and the MAC stage.
// The master drives one tap per strobe; the slave returns samples and status pulses.
interface fir_mac_if #(
   parameter int DATA_W  = 16,
   parameter int COEFF_W = 16,
   parameter int CNT_W   = 6
);
   logic                      en;
   logic [CNT_W-1:0]          current_count;
   logic signed [DATA_W-1:0]  input_mux;
   logic signed [COEFF_W-1:0] coeff;
   logic signed [DATA_W-1:0]  filter_out;
   logic                      out_valid;
   logic                      seq_err;

   modport master (
      output en, current_count, input_mux, coeff,
      input  filter_out, out_valid, seq_err
   );

   modport slave (
      input  en, current_count, input_mux, coeff,
      output filter_out, out_valid, seq_err
   );
endinterface

// File: rtl/fir_mac_accumulator.sv
// Serial multiply-accumulate for one 64-tap band filter: product, accumulate and
// round/saturate stages, with a tap-sequence FSM that discards out-of-order frames.
module fir_mac_accumulator #(
   parameter int NUM_TAPS  = 64,
   parameter int DATA_W    = 16,
   parameter int COEFF_W   = 16,
   parameter int ACC_W     = 40,
   parameter int FRAC_BITS = 15
) (
   input logic      clk,
   input logic      rst_n,
   fir_mac_if.slave bus
);
   localparam int CNT_W  = $clog2(NUM_TAPS);
   localparam int PROD_W = DATA_W + COEFF_W;
   localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(NUM_TAPS - 1);
   localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(1) <<< (FRAC_BITS - 1);
   localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] OUT_MIN  = -(ACC_W'(2 ** (DATA_W - 1)));

   typedef enum logic [1:0] {SYNC, ACCUM, DUMP} state_t;

   state_t                    state, state_next;
   logic signed [PROD_W-1:0]  p_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic                      v1;
   logic signed [ACC_W-1:0]   acc, acc_next, prod_ext, rnd;
   logic [CNT_W-1:0]          exp_cnt, exp_next;
   logic                      seq_err_next;
   logic signed [DATA_W-1:0]  sat_val, filter_q;
   logic                      out_valid_q, seq_err_q;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg   <= '0;
         cnt_reg <= '0;
         v1      <= 1'b0;
      end else begin
         v1 <= bus.en;
         if (bus.en) begin
            p_reg   <= bus.input_mux * bus.coeff;
            cnt_reg <= bus.current_count;
         end
      end
   end

   assign prod_ext = {{(ACC_W - PROD_W){p_reg[PROD_W-1]}}, p_reg};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next   = state;
      acc_next     = acc;
      exp_next     = exp_cnt;
      seq_err_next = 1'b0;
      case (state)
         SYNC: begin
            if (v1 && cnt_reg == '0) begin
               acc_next   = prod_ext;
               exp_next   = CNT_W'(1);
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (v1) begin
               if (cnt_reg == exp_cnt) begin
                  acc_next = (cnt_reg == '0) ? prod_ext : acc + prod_ext;
                  exp_next = exp_cnt + CNT_W'(1);
                  if (cnt_reg == LAST_TAP) state_next = DUMP;
               end else begin
                  seq_err_next = 1'b1;
                  if (cnt_reg == '0) begin
                     acc_next = prod_ext;
                     exp_next = CNT_W'(1);
                  end else begin
                     state_next = SYNC;
                  end
               end
            end
         end
         DUMP: begin
            state_next = ACCUM;
            exp_next   = '0;
            // A non-zero tap here belongs to no frame yet, so resync quietly.
            if (v1) begin
               if (cnt_reg == '0) begin
                  acc_next = prod_ext;
                  exp_next = CNT_W'(1);
               end else begin
                  state_next = SYNC;
               end
            end
         end
         default: state_next = SYNC;
      endcase
   end

   assign rnd = (acc + HALF) >>> FRAC_BITS;

   always_comb begin
      sat_val = rnd[DATA_W-1:0];
      if (rnd > OUT_MAX)      sat_val = OUT_MAX[DATA_W-1:0];
      else if (rnd < OUT_MIN) sat_val = OUT_MIN[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SYNC;
         acc         <= '0;
         exp_cnt     <= '0;
         filter_q    <= '0;
         out_valid_q <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         state       <= state_next;
         acc         <= acc_next;
         exp_cnt     <= exp_next;
         seq_err_q   <= seq_err_next;
         out_valid_q <= (state == DUMP);
         if (state == DUMP) filter_q <= sat_val;
      end
   end

   assign bus.filter_out = filter_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.seq_err    = seq_err_q;
endmodule
